// File: rtl/data_mem_lsu_pkg.sv
// Shared definitions for the data memory load/store unit.
//   INSTRUCTION_SIZE : datapath / address width in bits
//   funct3_e         : RV32I load/store width and sign codes
package data_mem_lsu_pkg;

  localparam int INSTRUCTION_SIZE = 32;

  // Width/sign codes carried in funct3 of loads and stores. Stores only use
  // the first three; the unsigned forms are load-only.
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

endpackage : data_mem_lsu_pkg

// File: rtl/data_mem_lsu_store_lane_steer.sv
// Store lane steering: turns a store width code and the low address bits
// into a per-byte write enable and replicates the store data so that every
// lane carries the bytes that may land in it.
//   funct3_i   : store width code
//   addrLo_i   : byte offset within the word
//   wdata_i    : raw store data (rs2)
//   byteEn_o   : one bit per byte lane, all zero on a misaligned or
//                illegal store
//   wdataRep_o : lane-replicated store data
module store_lane_steer
  import data_mem_lsu_pkg::*;
(
  input  logic [2:0]                  funct3_i,
  input  logic [1:0]                  addrLo_i,
  input  logic [INSTRUCTION_SIZE-1:0] wdata_i,
  output logic [3:0]                  byteEn_o,
  output logic [INSTRUCTION_SIZE-1:0] wdataRep_o
);

  // Replicating the data means the memory can write lane b from
  // wdataRep_o[8b+:8] without needing its own shifter.
  always_comb begin
    byteEn_o   = 4'b0000;
    wdataRep_o = wdata_i;
    case (funct3_i)
      F3_B: begin
        byteEn_o   = 4'b0001 << addrLo_i;
        wdataRep_o = {4{wdata_i[7:0]}};
      end
      F3_H: begin
        wdataRep_o = {2{wdata_i[15:0]}};
        if (!addrLo_i[0]) begin
          byteEn_o = addrLo_i[1] ? 4'b1100 : 4'b0011;
        end
      end
      F3_W: begin
        if (addrLo_i == 2'b00) begin
          byteEn_o = 4'b1111;
        end
      end
      default: begin
        byteEn_o = 4'b0000;
      end
    endcase
  end

endmodule : store_lane_steer

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32I data memory with load/store lane logic.
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears memory and error flag
//   mem_we     : store request (takes priority over mem_re)
//   mem_re     : load request
//   funct3     : load/store width and sign code
//   addr       : byte address; upper bits beyond the array alias
//   wdata      : store data
//   rdata      : extended load data, combinational
//   misaligned : current access is misaligned, combinational
//   err_sticky : latched flag of any misaligned or illegal access
module data_mem_lsu
  import data_mem_lsu_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_we,
  input  logic                        mem_re,
  input  logic [2:0]                  funct3,
  input  logic [INSTRUCTION_SIZE-1:0] addr,
  input  logic [INSTRUCTION_SIZE-1:0] wdata,
  output logic [INSTRUCTION_SIZE-1:0] rdata,
  output logic                        misaligned,
  output logic                        err_sticky
);

  logic [INSTRUCTION_SIZE-1:0] mem_q [DEPTH_WORDS];
  logic                        err_sticky_q;
  logic                        err_sticky_d;

  logic [AW-1:0]               wordIdx;
  logic                        accessActive;
  logic                        widthHalf;
  logic                        widthWord;
  logic                        storeLegal;
  logic                        loadLegal;
  logic                        illegal;
  logic                        fault;
  logic [3:0]                  byteEn;
  logic [INSTRUCTION_SIZE-1:0] wdataRep;
  logic [INSTRUCTION_SIZE-1:0] rdWord;
  logic [7:0]                  rdByte;
  logic [15:0]                 rdHalf;
  logic [INSTRUCTION_SIZE-1:0] loadData;
  logic                        unusedAddrHi;

  // Upper address bits are deliberately dropped so addresses alias.
  assign wordIdx      = addr[AW+1:2];
  assign unusedAddrHi = ^addr[INSTRUCTION_SIZE-1:AW+2];

  // Access classification. Legality is judged against the store codes
  // whenever a store is requested, since a store wins over a load.
  always_comb begin
    accessActive = mem_we | mem_re;
    widthHalf    = (funct3 == F3_H) || (funct3 == F3_HU);
    widthWord    = (funct3 == F3_W);
    storeLegal   = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    loadLegal    = storeLegal || (funct3 == F3_BU) || (funct3 == F3_HU);
    misaligned   = accessActive &
                   ((widthHalf & addr[0]) | (widthWord & (addr[1:0] != 2'b00)));
    illegal      = mem_we ? ~storeLegal : (mem_re & ~loadLegal);
    fault        = misaligned | illegal;
    err_sticky_d = err_sticky_q | fault;
  end

  store_lane_steer u_store_lane_steer (
    .funct3_i   (funct3),
    .addrLo_i   (addr[1:0]),
    .wdata_i    (wdata),
    .byteEn_o   (byteEn),
    .wdataRep_o (wdataRep)
  );

  // Memory array: the steer already drops faulting stores to a zero
  // byte-enable, so only the request and reset gate the write here.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < DEPTH_WORDS; w++) begin
        mem_q[w] <= '0;
      end
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) begin
          mem_q[wordIdx][8*b +: 8] <= wdataRep[8*b +: 8];
        end
      end
    end
  end

  // Error flag holds until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
    end else begin
      err_sticky_q <= err_sticky_d;
    end
  end

  assign err_sticky = err_sticky_q;

  // Load gather and extend. Reads the pre-edge array, so a store to the
  // same word becomes visible only after its commit edge.
  always_comb begin
    rdWord   = mem_q[wordIdx];
    rdHalf   = addr[1] ? rdWord[31:16] : rdWord[15:0];
    rdByte   = 8'h00;
    loadData = '0;
    case (addr[1:0])
      2'b00:   rdByte = rdWord[7:0];
      2'b01:   rdByte = rdWord[15:8];
      2'b10:   rdByte = rdWord[23:16];
      default: rdByte = rdWord[31:24];
    endcase
    if (mem_re && !mem_we && !fault) begin
      case (funct3)
        F3_B:    loadData = {{24{rdByte[7]}}, rdByte};
        F3_H:    loadData = {{16{rdHalf[15]}}, rdHalf};
        F3_W:    loadData = rdWord;
        F3_BU:   loadData = {24'h000000, rdByte};
        F3_HU:   loadData = {16'h0000, rdHalf};
        default: loadData = '0;
      endcase
    end
  end

  assign rdata = loadData;

endmodule : data_mem_lsu

// File: tb/tb_data_mem_lsu.sv
// Directed self-checking bench for data_mem_lsu. Each step drives one
// access, queues the values the outputs must show, and checkOutput drains
// the queue against the DUT shortly after the inputs settle.
module tb_data_mem_lsu;

  logic        clk;
  logic        rst;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        misaligned;
  logic        err_sticky;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] value;
  } expT;

  localparam int K_RDATA = 0;
  localparam int K_MIS   = 1;
  localparam int K_ERR   = 2;

  expT sbQ[$];
  int  checkCount = 0;
  int  failCount  = 0;

  data_mem_lsu #(.DEPTH_WORDS(256)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .misaligned (misaligned),
    .err_sticky (err_sticky)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge, well clear of the commit edge.
  task automatic applyStimulus(input logic r, input logic we, input logic re,
                               input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
    @(negedge clk);
    rst    = r;
    mem_we = we;
    mem_re = re;
    funct3 = f3;
    addr   = a;
    wdata  = wd;
  endtask

  task automatic pushExpect(input string tag, input int kind, input logic [31:0] v);
    expT e;
    e.tag   = tag;
    e.kind  = kind;
    e.value = v;
    sbQ.push_back(e);
  endtask

  // Compares every queued expectation against the settled outputs.
  task automatic checkOutput();
    expT         e;
    logic [31:0] obs;
    #1;
    while (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      case (e.kind)
        K_RDATA: obs = rdata;
        K_MIS:   obs = {31'd0, misaligned};
        default: obs = {31'd0, err_sticky};
      endcase
      checkCount++;
      assert (obs === e.value)
      else begin
        failCount++;
        $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mem_we = 1'b0; mem_re = 1'b0;
    funct3 = 3'b000; addr = '0; wdata = '0;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    pushExpect("reset_err", K_ERR, 32'd0);
    pushExpect("reset_rdata_idle", K_RDATA, 32'h0);
    checkOutput();

    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h00, 32'h0);
    pushExpect("lw_0x000_cleared", K_RDATA, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h04, 32'h0);
    pushExpect("lw_0x004_cleared", K_RDATA, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h3FC, 32'h0);
    pushExpect("lw_0x3fc_cleared", K_RDATA, 32'h0);
    pushExpect("err_after_reset_loads", K_ERR, 32'd0);
    checkOutput();

    // Full word store, then every load flavour over it
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF);
    pushExpect("sw_0x10_aligned", K_MIS, 32'd0);
    pushExpect("sw_0x10_rdata_zero", K_RDATA, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    pushExpect("lw_0x10", K_RDATA, 32'hDEADBEEF);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h0);
    pushExpect("lb_0x13", K_RDATA, 32'hFFFFFFDE);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b100, 32'h12, 32'h0);
    pushExpect("lbu_0x12", K_RDATA, 32'h000000AD);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b001, 32'h10, 32'h0);
    pushExpect("lh_0x10", K_RDATA, 32'hFFFFBEEF);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b101, 32'h12, 32'h0);
    pushExpect("lhu_0x12", K_RDATA, 32'h0000DEAD);
    checkOutput();

    // Byte and halfword lanes over a zeroed word
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b000, 32'h21, 32'h11223344);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    pushExpect("sb_lane1_word", K_RDATA, 32'h00004400);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b001, 32'h22, 32'hAAAA5566);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    pushExpect("sh_upper_word", K_RDATA, 32'h55664400);
    pushExpect("err_after_lanes", K_ERR, 32'd0);
    checkOutput();

    // Misaligned store writes nothing and latches the error
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h31, 32'hFFFFFFFF);
    pushExpect("sw_0x31_misaligned", K_MIS, 32'd1);
    pushExpect("sw_0x31_err_not_yet", K_ERR, 32'd0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h30, 32'h0);
    pushExpect("lw_0x30_unchanged", K_RDATA, 32'h0);
    pushExpect("err_after_misaligned", K_ERR, 32'd1);
    checkOutput();
    for (int i = 0; i < 5; i++) begin
      idle();
      pushExpect($sformatf("err_held_idle%0d", i), K_ERR, 32'd1);
      checkOutput();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    idle();
    pushExpect("err_cleared_by_rst", K_ERR, 32'd0);
    checkOutput();

    // Aliasing: 0x400 maps onto word 0
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h400, 32'h12345678);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h000, 32'h0);
    pushExpect("alias_lw_0x000", K_RDATA, 32'h12345678);
    checkOutput();

    // Read during write on the same word
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
    pushExpect("rdw_pre_lw_0x40", K_RDATA, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    pushExpect("rdw_store_priority", K_RDATA, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h40, 32'h0);
    pushExpect("rdw_post_lw_0x40", K_RDATA, 32'hCAFEF00D);
    pushExpect("err_before_illegal", K_ERR, 32'd0);
    checkOutput();

    // Illegal funct3
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b010, 32'h50, 32'h0BADF00D);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'b011, 32'h50, 32'hFFFFFFFF);
    pushExpect("illegal_store_not_misaligned", K_MIS, 32'd0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b010, 32'h50, 32'h0);
    pushExpect("illegal_store_no_write", K_RDATA, 32'h0BADF00D);
    pushExpect("err_after_illegal_store", K_ERR, 32'd1);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b110, 32'h50, 32'h0);
    pushExpect("illegal_load_rdata_zero", K_RDATA, 32'h0);
    checkOutput();

    // Misaligned halfword load returns zero
    applyStimulus(1'b0, 1'b0, 1'b1, 3'b101, 32'h11, 32'h0);
    pushExpect("lhu_0x11_misaligned", K_MIS, 32'd1);
    pushExpect("lhu_0x11_rdata_zero", K_RDATA, 32'h0);
    checkOutput();

    idle();
    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule : tb_data_mem_lsu

// File: doc/data_mem_lsu.md
Name: data_mem_lsu

Overview:
- Byte-addressable RV32I data memory with integrated load/store lane logic.
- Store path: scatters write data onto byte lanes, selected by address low bits and funct3. This is the 1-to-many direction of the datapath's 2:1 selection muxes.
- Load path: gathers the addressed lane and sign- or zero-extends it.
- Sits after the ALU (address) in the single-cycle datapath; rdata feeds the writeback mux.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words; power of two, at least 4.
- AW, $clog2(DEPTH_WORDS), word-index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mem_we  input  1  store request this cycle.
- mem_re  input  1  load request this cycle.
- funct3  input  3  load/store width and sign code from the instruction.
- addr  input  `INSTRUCTION_SIZE  byte address from the ALU.
- wdata  input  `INSTRUCTION_SIZE  store data (rs2).
- rdata  output  `INSTRUCTION_SIZE  extended load data, combinational.
- misaligned  output  1  current access is misaligned, combinational.
- err_sticky  output  1  registered flag; latches any faulting access.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset state: on any edge with rst=1, all DEPTH_WORDS words are cleared to 0 and err_sticky is cleared to 0. Stores are suppressed during reset.
- Word index and aliasing: word index = addr[AW+1:2]. Upper address bits are ignored, so out-of-range addresses alias modulo DEPTH_WORDS.
- Store funct3 encodings: 000 SB, 001 SH, 010 SW.
- Load funct3 encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Illegal access: any other funct3 used with an active access.
- misaligned = (mem_we|mem_re) & ((width is H and addr[0]=1) | (width is W and addr[1:0]!=0)).
  - Width H = funct3 001/101.
  - Width W = funct3 010.
- Store commit: occurs on the rising edge when rst=0, mem_we=1, misaligned=0 and funct3 is a legal store.
  - SB: writes wdata[7:0] to byte lane addr[1:0].
  - SH: writes wdata[15:0] to halfword lane addr[1].
  - SW: writes the full word.
  - Unselected lanes of the word are unchanged.
- Faulting store: a misaligned or illegal store writes nothing.
- Load (combinational): when mem_re=1 and mem_we=0, rdata = selected lane of the current array word, then extended.
  - LB/LH: sign-extend. LBU/LHU: zero-extend. LW: full word.
  - Misaligned or illegal load: rdata = 0.
- rdata = 0 when mem_re=0, or when mem_we=1 (store has priority when both are asserted).
- Read-during-write, same word: rdata shows pre-edge contents; new data is visible the cycle after the edge.
- err_sticky: set on the edge when rst=0 and an active access (mem_we|mem_re) is misaligned or has illegal funct3. It stays set until rst.
- Latency: loads 0 cycles (combinational); stores commit at the next edge.

Decomposition:
- RISCV_PKG.vh (shared header):
  - INSTRUCTION_SIZE (32).
  - F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- Sub-module store_lane_steer (combinational): inputs funct3, addr[1:0], wdata. Outputs 4-bit byte-enable and lane-replicated 32-bit write data. Byte-enable is 0000 on a misaligned or illegal access.
- Load extraction/extension stays inline in data_mem_lsu.

Test Plan:
- Reset, then LW at 0x00, 0x04, 0x3FC -> rdata=0x00000000 each; err_sticky=0.
- SW 0xDEADBEEF @0x10, next cycle:
  - LW @0x10 -> 0xDEADBEEF.
  - LB @0x13 -> 0xFFFFFFDE.
  - LBU @0x12 -> 0x000000AD.
  - LH @0x10 -> 0xFFFFBEEF.
  - LHU @0x12 -> 0x0000DEAD.
- Byte lanes over a zeroed word: SB 0x11223344 @0x21 -> LW @0x20 = 0x00004400. Then SH 0xAAAA5566 @0x22 -> LW @0x20 = 0x55664400.
- Misaligned store: SW 0xFFFFFFFF @0x31 -> misaligned=1 same cycle; word @0x30 unchanged (0); err_sticky=1 after the edge and held through 5 idle cycles. rst pulse -> err_sticky=0.
- Aliasing and read-during-write (DEPTH_WORDS=256): SW 0x12345678 @0x400 -> LW @0x000 = 0x12345678. Same-cycle SW plus LW probe @0x40 -> old value before the edge, new value after.
- Illegal funct3: funct3=011 with mem_we=1 @0x50 -> no write; err_sticky=1. LW @0x50 with funct3=110 and mem_re=1 -> rdata=0.
